// File: rtl/celula_ram_sync.sv
// -----------------------------------------------------------------------------
// celula_ram_sync
// -----------------------------------------------------------------------------
// Purpose:
//   One storage cell of the SAP-1 16x4 RAM array (74189-style). It holds one
//   word of WIDTH bits. The parent RAM drives the cell as follows:
//     - sel comes from its row decode gated with chip enable.
//     - w is its global write strobe.
//     - It muxes/tri-states q onto the read bus.
//   The stored value is always presented on q. The cell itself does no read
//   gating.
//
// Parameters:
//   WIDTH      bits stored per cell (the SAP-1 array uses 1)
//   RESET_VAL  value loaded on reset
//
// Ports:
//   clk    in   1      rising-edge clock, the only clock domain
//   n_clr  in   1      synchronous reset, active-low
//   d      in   WIDTH  write data
//   w      in   1      write strobe, active-high
//   sel    in   1      cell select, active-high
//   q      out  WIDTH  stored value, straight from the register
//   dirty  out  1      present only when CELULA_RAM_DIRTY_EN is defined;
//                      high once the cell has been written since reset
//
// Build option:
//   CELULA_RAM_DIRTY_EN  adds the sticky 'dirty' flag and its port. The
//                        behaviour of q is the same in both builds.
// -----------------------------------------------------------------------------
module celula_ram_sync #(
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             n_clr,
    input  logic [WIDTH-1:0] d,
    input  logic             w,
    input  logic             sel,
    output logic [WIDTH-1:0] q
`ifdef CELULA_RAM_DIRTY_EN
    ,
    output logic             dirty
`endif
);

    // A write needs both the global strobe and this cell's select.
    logic             write_en;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    assign write_en = w & sel;

    always_comb begin
        data_d = data_q;
        if (write_en) begin
            data_d = d;
        end
    end

    // Reset takes priority over a write on the same edge. That write is
    // dropped, not held over to a later edge.
    always_ff @(posedge clk) begin
        if (!n_clr) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

`ifdef CELULA_RAM_DIRTY_EN
    // Sticky written-since-reset flag. It updates on the same edge as data_q.
    logic dirty_q;
    logic dirty_d;

    always_comb begin
        dirty_d = dirty_q | write_en;
    end

    always_ff @(posedge clk) begin
        if (!n_clr) begin
            dirty_q <= 1'b0;
        end else begin
            dirty_q <= dirty_d;
        end
    end

    assign dirty = dirty_q;
`endif

endmodule

// File: tb/tb_celula_ram_sync.sv
// -----------------------------------------------------------------------------
// tb_celula_ram_sync
// -----------------------------------------------------------------------------
// Directed bench for celula_ram_sync. It uses three fixtures:
//   - dut    : 1-bit cell used for reset, write, hold, priority and lag tests.
//   - dut_rv : 4-bit cell with a non-zero RESET_VAL.
//   - array  : parent-style 16x4 array of 1-bit cells with one-hot row select.
// Inputs change 1 time unit after the rising edge, and outputs are sampled at
// that same point.
// -----------------------------------------------------------------------------
module tb_celula_ram_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Shared reset.
    logic n_clr;

    // Main 1-bit cell.
    logic d, w, sel;
    logic q;

    // 4-bit cell with RESET_VAL = 4'hA.
    logic [3:0] rv_d;
    logic       rv_w, rv_sel;
    logic [3:0] rv_q;

    // 16x4 array built from 1-bit cells.
    logic [3:0]        arr_d;
    logic              arr_w;
    logic [15:0]       arr_sel;
    logic [15:0][3:0]  arr_q;

`ifdef CELULA_RAM_DIRTY_EN
    logic              dirty;
    logic              rv_dirty;
    logic [15:0][3:0]  arr_dirty;
`endif

    celula_ram_sync #(.WIDTH(1), .RESET_VAL(1'b0)) dut (
        .clk   (clk),
        .n_clr (n_clr),
        .d     (d),
        .w     (w),
        .sel   (sel),
        .q     (q)
`ifdef CELULA_RAM_DIRTY_EN
        ,
        .dirty (dirty)
`endif
    );

    celula_ram_sync #(.WIDTH(4), .RESET_VAL(4'hA)) dut_rv (
        .clk   (clk),
        .n_clr (n_clr),
        .d     (rv_d),
        .w     (rv_w),
        .sel   (rv_sel),
        .q     (rv_q)
`ifdef CELULA_RAM_DIRTY_EN
        ,
        .dirty (rv_dirty)
`endif
    );

    for (genvar gi = 0; gi < 16; gi++) begin : g_row
        for (genvar gb = 0; gb < 4; gb++) begin : g_bit
            celula_ram_sync #(.WIDTH(1), .RESET_VAL(1'b0)) u_cell (
                .clk   (clk),
                .n_clr (n_clr),
                .d     (arr_d[gb]),
                .w     (arr_w),
                .sel   (arr_sel[gi]),
                .q     (arr_q[gi][gb])
`ifdef CELULA_RAM_DIRTY_EN
                ,
                .dirty (arr_dirty[gi][gb])
`endif
            );
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] pattern;
        logic [3:0] exp_row;

        // Test 1: reset held for 2 edges while a write is requested.
        n_clr = 1'b0; d = 1'b1; w = 1'b1; sel = 1'b1;
        rv_d = 4'h5; rv_w = 1'b1; rv_sel = 1'b1;
        arr_d = 4'h0; arr_w = 1'b0; arr_sel = 16'h0;
        tick();
        check("rst_edge1", {3'b0, q}, 4'h0);
        check("rv_rst_edge1", rv_q, 4'hA);
        tick();
        check("rst_edge2", {3'b0, q}, 4'h0);
        check("rv_rst_edge2", rv_q, 4'hA);
`ifdef CELULA_RAM_DIRTY_EN
        check("dirty_rst", {3'b0, dirty}, 4'h0);
`endif

        // Test 2: single write. q changes after the edge, not before.
        n_clr = 1'b1;
        #2;
        check("wr_before_edge", {3'b0, q}, 4'h0);
        tick();
        check("wr_after_edge", {3'b0, q}, 4'h1);
        check("rv_wr", rv_q, 4'h5);
`ifdef CELULA_RAM_DIRTY_EN
        check("dirty_after_wr", {3'b0, dirty}, 4'h1);
`endif

        // Test 3: hold with sel=0, then hold with read (sel=1, w=0).
        sel = 1'b0; w = 1'b1; d = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_unsel", {3'b0, q}, 4'h1);
        end
        sel = 1'b1; w = 1'b0; d = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_read", {3'b0, q}, 4'h1);
        end

        // Test 4: reset beats a simultaneous write; writes resume after release.
        n_clr = 1'b0; w = 1'b1; sel = 1'b1; d = 1'b1;
        tick();
        check("rst_prio", {3'b0, q}, 4'h0);
        check("rv_rst_prio", rv_q, 4'hA);
`ifdef CELULA_RAM_DIRTY_EN
        check("dirty_rst_prio", {3'b0, dirty}, 4'h0);
`endif
        n_clr = 1'b1;
        tick();
        check("rst_release_wr", {3'b0, q}, 4'h1);

        // Test 5: back-to-back writes 0,1,0,1. q follows d one edge later.
        pattern = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            d = pattern[i];
            #2;
            check("b2b_before", {3'b0, q}, (i == 0) ? 4'h1 : {3'b0, pattern[i-1]});
            tick();
            check("b2b_after", {3'b0, q}, {3'b0, pattern[i]});
        end

        // Glitch on d between edges. Only the value present at the edge counts.
        #2 d = 1'b0;
        #1 check("glitch_mid", {3'b0, q}, 4'h1);
        #1 d = 1'b1;
        tick();
        check("glitch_edge", {3'b0, q}, 4'h1);
        // Glitch while holding (w=0). Nothing is written.
        w = 1'b0;
        #2 d = 1'b0;
        tick();
        check("glitch_hold", {3'b0, q}, 4'h1);

        // Test 6: parent-style 16x4 array with one-hot select.
        arr_w = 1'b1;
        arr_sel = 16'h0001 << 5; arr_d = 4'b1010;
        tick();
        arr_sel = 16'h0001 << 6; arr_d = 4'b0101;
        tick();
        arr_w = 1'b0; arr_sel = 16'h0; arr_d = 4'b1111;
        tick();
        for (int r = 0; r < 16; r++) begin
            exp_row = (r == 5) ? 4'b1010 : (r == 6) ? 4'b0101 : 4'b0000;
            check($sformatf("array_row%0d", r), arr_q[r], exp_row);
`ifdef CELULA_RAM_DIRTY_EN
            check($sformatf("array_dirty%0d", r), arr_dirty[r],
                  (r == 5 || r == 6) ? 4'hF : 4'h0);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
